// File: rtl/orb_frame_pkg.sv
// Shared types and constants for the trace frame byte streamer.
package orb_frame_pkg;

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    STAT = 3'd1,
    IDLE = 3'd2,
    HDR  = 3'd3,
    DATA = 3'd4
  } frameStateE;

  // Sent least-significant byte first: FF FF FF 7F.
  localparam logic [31:0] SYNC_BYTES    = 32'h7FFF_FFFF;
  localparam logic [3:0]  HDR_FRAME_NIB = 4'hA;
  localparam logic [7:0]  HDR_STATUS    = 8'hA8;
  localparam int          FRAME_BYTES   = 16;

  function automatic logic [7:0] frameHeader(input logic [1:0] width);
    return {HDR_FRAME_NIB, 2'b00, width};
  endfunction

endpackage

// File: rtl/frame_shift_reg.sv
// 128-bit frame holding register, unloaded one byte at a time, LSB byte first.
module frame_shift_reg
  import orb_frame_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] frameIn,
  input  logic         shift,
  output logic [7:0]   curByte,
  output logic         last
);

  logic [127:0] data;
  logic [3:0]   idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      idx  <= '0;
    end else if (load) begin
      data <= frameIn;
      idx  <= '0;
    end else if (shift) begin
      data <= {8'h00, data[127:8]};
      idx  <= idx + 4'd1;
    end
  end

  assign curByte = data[7:0];
  assign last    = (idx == 4'(FRAME_BYTES - 1));

endmodule

// File: rtl/frame_byte_streamer.sv
// Serialises buffered 128-bit trace frames into header + 16 bytes with periodic sync.
// Optional status packet after each sync when FRAME_STATUS_PKT_EN is defined.
//
// state | meaning
// SYNC  | emitting FF FF FF 7F re-alignment sequence
// STAT  | emitting 8-byte status packet (FRAME_STATUS_PKT_EN only)
// IDLE  | waiting for a frame; pops it the cycle FrameReady is seen
// HDR   | emitting frame header {A, 00, width}
// DATA  | emitting the 16 latched frame bytes
module frame_byte_streamer
  import orb_frame_pkg::*;
#(
  parameter int BUFFLENLOG2   = 9,
  parameter int SYNC_INTERVAL = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             Width,
  input  logic [127:0]           Frame,
  input  logic                   FrameReady,
  input  logic [BUFFLENLOG2-1:0] FramesCnt,
  output logic                   FrameNext,
  output logic [7:0]             DataVal,
  output logic                   DataReady,
  input  logic                   DataNext,
  input  logic [7:0]             Leds,
  input  logic [31:0]            TotalFrames,
  input  logic [15:0]            LostFrames
);

  frameStateE state;
  logic       armed;
  logic [2:0] subIdx;
  logic [7:0] frameCnt;
  logic [7:0] cntNext;
  logic [1:0] widthLat;
  logic [7:0] frameByte;
  logic       frameLast;
  logic       fire;

  // armed keeps DataReady low during and for one cycle after reset.
  assign DataReady = armed && (state != IDLE);
  assign FrameNext = armed && (state == IDLE) && FrameReady;
  assign fire      = DataReady && DataNext;
  assign cntNext   = (frameCnt == 8'hFF) ? frameCnt : frameCnt + 8'd1;

  frame_shift_reg uShift (
    .clk     (clk),
    .rst     (rst),
    .load    (FrameNext),
    .frameIn (Frame),
    .shift   (fire && (state == DATA)),
    .curByte (frameByte),
    .last    (frameLast)
  );

`ifdef FRAME_STATUS_PKT_EN
  logic [63:0] statSnap;
  logic        unusedInputs;
  assign unusedInputs = ^FramesCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statSnap <= '0;
    end else if ((state == SYNC) && fire && (subIdx == 3'd3)) begin
      statSnap <= {LostFrames, TotalFrames, Leds, HDR_STATUS};
    end
  end
`else
  logic unusedInputs;
  assign unusedInputs = ^{FramesCnt, Leds, TotalFrames, LostFrames};
`endif

  always_comb begin
    DataVal = 8'h00;
    if (DataReady) begin
      unique case (state)
        SYNC:    DataVal = SYNC_BYTES[{subIdx[1:0], 3'b000} +: 8];
`ifdef FRAME_STATUS_PKT_EN
        STAT:    DataVal = statSnap[{subIdx, 3'b000} +: 8];
`endif
        HDR:     DataVal = frameHeader(widthLat);
        DATA:    DataVal = frameByte;
        default: DataVal = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed    <= 1'b0;
      state    <= SYNC;
      subIdx   <= '0;
      frameCnt <= '0;
      widthLat <= '0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        SYNC: if (fire) begin
          if (subIdx == 3'd3) begin
            subIdx   <= '0;
            frameCnt <= '0;
`ifdef FRAME_STATUS_PKT_EN
            state    <= STAT;
`else
            state    <= IDLE;
`endif
          end else begin
            subIdx <= subIdx + 3'd1;
          end
        end
`ifdef FRAME_STATUS_PKT_EN
        STAT: if (fire) begin
          if (subIdx == 3'd7) begin
            subIdx <= '0;
            state  <= IDLE;
          end else begin
            subIdx <= subIdx + 3'd1;
          end
        end
`endif
        IDLE: if (FrameNext) begin
          widthLat <= Width;
          state    <= HDR;
        end
        HDR: if (fire) state <= DATA;
        DATA: if (fire && frameLast) begin
          frameCnt <= cntNext;
          state    <= (cntNext >= 8'(SYNC_INTERVAL)) ? SYNC : IDLE;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_byte_streamer.sv
// Directed bench for frame_byte_streamer (default build, SYNC_INTERVAL=2).
module tb_frame_byte_streamer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   Width = 2'd0;
  logic [127:0] Frame = '0;
  logic         FrameReady = 1'b0;
  logic [8:0]   FramesCnt = '0;
  logic         FrameNext;
  logic [7:0]   DataVal;
  logic         DataReady;
  logic         DataNext = 1'b1;
  logic [7:0]   Leds = 8'h3C;
  logic [31:0]  TotalFrames = 32'h1234_5678;
  logic [15:0]  LostFrames = 16'h9ABC;

  frame_byte_streamer #(.BUFFLENLOG2(9), .SYNC_INTERVAL(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .Width       (Width),
    .Frame       (Frame),
    .FrameReady  (FrameReady),
    .FramesCnt   (FramesCnt),
    .FrameNext   (FrameNext),
    .DataVal     (DataVal),
    .DataReady   (DataReady),
    .DataNext    (DataNext),
    .Leds        (Leds),
    .TotalFrames (TotalFrames),
    .LostFrames  (LostFrames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] frame;
    logic [1:0]   width;
    bit           stall;
    bit           syncAfter;
  } vecT;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [127:0] bufQ[$];
  logic [7:0]   rxQ[$];
  int           stampQ[$];
  logic [7:0]   expQ[$];
  bit   popSeen = 1'b0;
  int   popCount = 0;
  int   lastPopCyc = 0;
  bit   stallMode = 1'b0;
  bit   prevStall = 1'b0;
  logic [7:0] heldVal = 8'h00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte/pop monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (prevStall && DataReady) chk("stall_hold", DataVal, heldVal);
      prevStall = DataReady && !DataNext;
      heldVal   = DataVal;
      if (DataReady && DataNext) begin
        rxQ.push_back(DataVal);
        stampQ.push_back(cyc);
      end
      if (FrameNext) begin
        popSeen    = 1'b1;
        popCount++;
        lastPopCyc = cyc;
      end
    end else begin
      prevStall = 1'b0;
    end
  end

  // Show-ahead frame buffer model and consumer back-pressure.
  always @(posedge clk) begin
    #1;
    if (popSeen) begin
      if (bufQ.size() > 0) void'(bufQ.pop_front());
      popSeen = 1'b0;
    end
    FrameReady = (bufQ.size() != 0);
    Frame      = FrameReady ? bufQ[0] : '0;
    FramesCnt  = 9'(bufQ.size());
    DataNext   = stallMode ? ~DataNext : 1'b1;
  end

  function automatic void expFrame(input logic [127:0] f, input logic [1:0] w);
    expQ.push_back({4'hA, 2'b00, w});
    for (int k = 0; k < 16; k++) expQ.push_back(f[k*8 +: 8]);
  endfunction

  function automatic void expSync();
    expQ.push_back(8'hFF);
    expQ.push_back(8'hFF);
    expQ.push_back(8'hFF);
    expQ.push_back(8'h7F);
  endfunction

  function automatic void clearStream();
    rxQ.delete();
    stampQ.delete();
    expQ.delete();
  endfunction

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic waitStream(input string name, input int budget);
    int n = 0;
    while (rxQ.size() < expQ.size() && n < budget) begin
      cycle();
      n++;
    end
    repeat (4) cycle();
    chk({name, "_len"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
      chk($sformatf("%s_b%0d", name, i), rxQ[i], expQ[i]);
  endtask

  localparam logic [127:0] FA = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] FB = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [127:0] FC = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] FD = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;

  vecT vt[4];
  logic [127:0] f5[5];

  initial begin
    int p0;
    int n;
    vt[0] = '{frame: FA, width: 2'd3, stall: 1'b0, syncAfter: 1'b0};
    vt[1] = '{frame: FB, width: 2'd2, stall: 1'b1, syncAfter: 1'b1};
    vt[2] = '{frame: FC, width: 2'd0, stall: 1'b0, syncAfter: 1'b0};
    vt[3] = '{frame: FD, width: 2'd1, stall: 1'b1, syncAfter: 1'b1};
    for (int i = 0; i < 5; i++) f5[i] = FA ^ {16{8'(8'h11 * (i + 1))}};

    rst = 1'b0;
    repeat (3) cycle();
    chk("rst_ready", DataReady, 1'b0);
    chk("rst_val", DataVal, 8'h00);
    chk("rst_pop", FrameNext, 1'b0);

    rst = 1'b1;
    expSync();
    waitStream("sync0", 20);
    chk("idle_ready0", DataReady, 1'b0);
    chk("no_pop0", popCount, 0);
    clearStream();

    for (int v = 0; v < 4; v++) begin
      Width     = vt[v].width;
      stallMode = vt[v].stall;
      p0        = popCount;
      bufQ.push_back(vt[v].frame);
      expFrame(vt[v].frame, vt[v].width);
      if (vt[v].syncAfter) expSync();
      waitStream($sformatf("vec%0d", v), 150);
      chk($sformatf("vec%0d_pops", v), popCount - p0, 1);
      if (stampQ.size() >= 17) begin
        chk($sformatf("vec%0d_span", v), stampQ[16] - stampQ[0], vt[v].stall ? 32 : 16);
        if (!vt[v].stall) chk($sformatf("vec%0d_hdr_lat", v), stampQ[0] - lastPopCyc, 1);
      end
      chk($sformatf("vec%0d_idle", v), DataReady, 1'b0);
      stallMode = 1'b0;
      clearStream();
    end

    // Five back-to-back frames: sync after the 2nd and 4th.
    Width = 2'd1;
    p0    = popCount;
    for (int i = 0; i < 5; i++) begin
      bufQ.push_back(f5[i]);
      expFrame(f5[i], 2'd1);
      if (i == 1 || i == 3) expSync();
    end
    waitStream("burst", 400);
    chk("burst_pops", popCount - p0, 5);
    clearStream();

    // Width change mid-DATA; counter is 1 so a sync follows the first frame.
    Width = 2'd3;
    bufQ.push_back(FB);
    expFrame(FB, 2'd3);
    expSync();
    expFrame(FC, 2'd1);
    n = 0;
    while (rxQ.size() < 6 && n < 50) begin
      cycle();
      n++;
    end
    Width = 2'd1;
    bufQ.push_back(FC);
    waitStream("width", 200);
    clearStream();

    // Reset while data byte 7 is presented.
    Width = 2'd2;
    bufQ.push_back(FA);
    n = 0;
    while (rxQ.size() < 8 && n < 50) begin
      cycle();
      n++;
    end
    chk("mid_ready", DataReady, 1'b1);
    chk("mid_val", DataVal, 8'h07);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", DataReady, 1'b0);
    chk("mid_rst_pop", FrameNext, 1'b0);
    repeat (2) cycle();
    rst = 1'b1;
    clearStream();
    Width = 2'd0;
    p0    = popCount;
    bufQ.push_back(FD);
    expSync();
    expFrame(FD, 2'd0);
    waitStream("post_rst", 100);
    chk("post_rst_pops", popCount - p0, 1);
    chk("post_rst_idle", DataReady, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
